// File: rtl/stream_averager_pkg.sv
// Shared definitions for the stream averager: FSM state encodings,
// handshake levels and accumulator sizing.
package stream_averager_pkg;

    typedef enum logic [1:0] {
        ST_ACCEPT = 2'd0,
        ST_DIVIDE = 2'd1,
        ST_SEND   = 2'd2
    } state_t;

    localparam logic HS_IDLE  = 1'b0;
    localparam logic HS_READY = 1'b1;

    // One guard bit beyond WIDTH+LOG2_N keeps a full block of extreme samples exact.
    function automatic int acc_width(input int width, input int log2_n);
        return width + log2_n + 1;
    endfunction

endpackage

// File: rtl/stream_averager_scale.sv
// avg_scale: turns a block sum into the block mean (shift plus truncate).
// With AVERAGER_ROUND_EN defined the mean rounds half up; otherwise it floors.
module avg_scale
    import stream_averager_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int LOG2_N = 2
) (
    input  logic signed [acc_width(WIDTH, LOG2_N)-1:0] acc,
    output logic        [WIDTH-1:0]                    result
);

    localparam int AW = acc_width(WIDTH, LOG2_N);

    logic signed [AW-1:0] biased;

`ifdef AVERAGER_ROUND_EN
    generate
        if (LOG2_N > 0) begin : g_round
            localparam logic signed [AW-1:0] HALF = AW'(1 << (LOG2_N - 1));
            // The guard bit absorbs the offset: max block sum plus N/2 still fits.
            assign biased = acc + HALF;
        end else begin : g_pass
            assign biased = acc;
        end
    endgenerate
`else
    assign biased = acc;
`endif

    // The mean of WIDTH-bit samples always fits in WIDTH bits, so truncation is exact.
    assign result = WIDTH'(biased >>> LOG2_N);

endmodule

// File: rtl/stream_averager.sv
// stream_averager: accumulates blocks of 2**LOG2_N signed samples and emits
// one block mean per block over stb/ack. Rounding mode set by AVERAGER_ROUND_EN.
module stream_averager
    import stream_averager_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int LOG2_N = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] input_z,
    input  logic             input_z_stb,
    output logic             input_z_ack,
    output logic [WIDTH-1:0] output_mean,
    output logic             output_mean_stb,
    input  logic             output_mean_ack
);

    localparam int AW = acc_width(WIDTH, LOG2_N);
    localparam int CW = LOG2_N + 1;
    localparam logic [CW-1:0] LAST = CW'((1 << LOG2_N) - 1);

    state_t               state_reg;
    logic signed [AW-1:0] acc_reg;
    logic [CW-1:0]        count_reg;
    logic [WIDTH-1:0]     mean_next;
    logic signed [AW-1:0] sample_ext;

    assign sample_ext = {{(AW - WIDTH){input_z[WIDTH-1]}}, input_z};

    avg_scale #(
        .WIDTH  (WIDTH),
        .LOG2_N (LOG2_N)
    ) u_scale (
        .acc    (acc_reg),
        .result (mean_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= ST_ACCEPT;
            acc_reg         <= '0;
            count_reg       <= '0;
            input_z_ack     <= HS_IDLE;
            output_mean_stb <= HS_IDLE;
            output_mean     <= '0;
        end else begin
            case (state_reg)
                ST_ACCEPT: begin
                    input_z_ack <= HS_READY;
                    if (input_z_stb && input_z_ack) begin
                        acc_reg <= acc_reg + sample_ext;
                        if (count_reg == LAST) begin
                            // Stop accepting until the mean has been handed off.
                            input_z_ack <= HS_IDLE;
                            count_reg   <= '0;
                            state_reg   <= ST_DIVIDE;
                        end else begin
                            count_reg <= count_reg + 1'b1;
                        end
                    end
                end
                ST_DIVIDE: begin
                    output_mean <= mean_next;
                    acc_reg     <= '0;
                    state_reg   <= ST_SEND;
                end
                ST_SEND: begin
                    output_mean_stb <= HS_READY;
                    if (output_mean_stb && output_mean_ack) begin
                        output_mean_stb <= HS_IDLE;
                        input_z_ack     <= HS_READY;
                        state_reg       <= ST_ACCEPT;
                    end
                end
                default: begin
                    state_reg <= ST_ACCEPT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stream_averager.sv
// Self-checking bench for stream_averager (WIDTH=16, LOG2_N=2): vector table,
// directed latency/backpressure/reset sequences and a randomised stream vs. a block-mean model.
module tb_stream_averager;

    localparam int WIDTH  = 16;
    localparam int LOG2_N = 2;
    localparam int N      = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [WIDTH-1:0] input_z;
    logic             input_z_stb;
    logic             input_z_ack;
    logic [WIDTH-1:0] output_mean;
    logic             output_mean_stb;
    logic             output_mean_ack;

    always #5 clk = ~clk;

    stream_averager #(
        .WIDTH  (WIDTH),
        .LOG2_N (LOG2_N)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .input_z         (input_z),
        .input_z_stb     (input_z_stb),
        .input_z_ack     (input_z_ack),
        .output_mean     (output_mean),
        .output_mean_stb (output_mean_stb),
        .output_mean_ack (output_mean_ack)
    );

    int total  = 0;
    int passed = 0;

    typedef struct {
        string            name;
        logic [3:0][15:0] s;
        logic [15:0]      exp_floor;
        logic [15:0]      exp_round;
    } vec_t;

    vec_t              vecs[8];
    logic [15:0]       exp_q[$];
    bit                send_done;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Mean of a block sum using plain integer division, floored toward -inf.
    function automatic logic [15:0] ref_mean(input int sum);
        int num;
        int q;
`ifdef AVERAGER_ROUND_EN
        num = sum + N / 2;
`else
        num = sum;
`endif
        q = num / N;
        if (num < 0 && (num % N) != 0) q = q - 1;
        return q[15:0];
    endfunction

    function automatic logic [15:0] pick(input vec_t v);
`ifdef AVERAGER_ROUND_EN
        return v.exp_round;
`else
        return v.exp_floor;
`endif
    endfunction

    // Called just after a negedge; returns just after the negedge following the transfer.
    task automatic send(input logic [15:0] v, output bit ok);
        bit a;
        ok          = 1'b0;
        input_z     = v;
        input_z_stb = 1'b1;
        for (int t = 0; t < 200 && !ok; t++) begin
            a = input_z_ack;
            tick();
            if (a) ok = 1'b1;
        end
        input_z_stb = 1'b0;
    endtask

    task automatic recv(output logic [15:0] v, output bit ok);
        bit          s;
        logic [15:0] cur;
        ok              = 1'b0;
        v               = '0;
        output_mean_ack = 1'b1;
        for (int t = 0; t < 50 && !ok; t++) begin
            s   = output_mean_stb;
            cur = output_mean;
            tick();
            if (s) begin
                ok = 1'b1;
                v  = cur;
            end
        end
        output_mean_ack = 1'b0;
    endtask

    task automatic send_block(input string name, input logic [3:0][15:0] s);
        bit ok;
        for (int i = 0; i < N; i++) begin
            send(s[i], ok);
            chk({name, "_send"}, 32'(ok), 32'd1);
        end
    endtask

    initial begin
        bit          ok;
        bit          hold_ok;
        logic [15:0] v;
        logic [15:0] held;
        int          outs;

        vecs[0] = '{"inc",       {16'h0004, 16'h0003, 16'h0002, 16'h0001}, 16'h0002, 16'h0003};
        vecs[1] = '{"neg_dec",   {16'hFFFC, 16'hFFFD, 16'hFFFE, 16'hFFFF}, 16'hFFFD, 16'hFFFE};
        vecs[2] = '{"max_pos",   {16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF}, 16'h7FFF, 16'h7FFF};
        vecs[3] = '{"max_neg",   {16'h8000, 16'h8000, 16'h8000, 16'h8000}, 16'h8000, 16'h8000};
        vecs[4] = '{"half_up",   {16'h0002, 16'h0002, 16'h0001, 16'h0001}, 16'h0001, 16'h0002};
        vecs[5] = '{"neg_small", {16'h0000, 16'h0000, 16'h0000, 16'hFFFF}, 16'hFFFF, 16'h0000};
        vecs[6] = '{"mixed",     {16'h0000, 16'h0003, 16'h8000, 16'h7FFF}, 16'h0000, 16'h0001};
        vecs[7] = '{"neg_half",  {16'h0000, 16'h0000, 16'h0000, 16'hFFFE}, 16'hFFFF, 16'h0000};

        rst             = 1'b1;
        input_z         = '0;
        input_z_stb     = 1'b0;
        output_mean_ack = 1'b0;
        send_done       = 1'b0;

        // Reset state
        repeat (3) tick();
        chk("rst_ack", 32'(input_z_ack), 32'd0);
        chk("rst_stb", 32'(output_mean_stb), 32'd0);
        chk("rst_mean", 32'(output_mean), 32'd0);
        rst = 1'b0;
        tick();
        chk("ack_after_rst", 32'(input_z_ack), 32'd1);

        // Latency: stb must rise two edges after the last accept
        send_block("lat", vecs[0].s);
        chk("lat_edge_k", 32'(output_mean_stb), 32'd0);
        tick();
        chk("lat_edge_k1", 32'(output_mean_stb), 32'd0);
        chk("lat_ack_low", 32'(input_z_ack), 32'd0);
        tick();
        chk("lat_edge_k2", 32'(output_mean_stb), 32'd1);
        chk("lat_value", 32'(output_mean), 32'(pick(vecs[0])));

        // Backpressure: hold for 10 cycles, then release
        held    = output_mean;
        hold_ok = 1'b1;
        input_z = 16'h1234;
        input_z_stb = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (!(output_mean_stb === 1'b1 && output_mean === held && input_z_ack === 1'b0))
                hold_ok = 1'b0;
            tick();
        end
        input_z_stb = 1'b0;
        chk("bp_hold", 32'(hold_ok), 32'd1);
        output_mean_ack = 1'b1;
        tick();
        output_mean_ack = 1'b0;
        chk("bp_release_stb", 32'(output_mean_stb), 32'd0);
        chk("bp_release_ack", 32'(input_z_ack), 32'd1);

        // Vector table
        for (int k = 0; k < 8; k++) begin
            send_block(vecs[k].name, vecs[k].s);
            recv(v, ok);
            chk({vecs[k].name, "_recv"}, 32'(ok), 32'd1);
            chk({vecs[k].name, "_mean"}, 32'(v), 32'(pick(vecs[k])));
        end

        // Reset mid-block discards the partial sum
        send(16'd7, ok);
        send(16'd7, ok);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        send_block("rst_mid", {16'd5, 16'd5, 16'd5, 16'd5});
        outs = 0;
        v    = '0;
        output_mean_ack = 1'b1;
        for (int t = 0; t < 30; t++) begin
            if (output_mean_stb) begin
                outs++;
                v = output_mean;
            end
            tick();
        end
        output_mean_ack = 1'b0;
        chk("rst_mid_count", 32'(outs), 32'd1);
        chk("rst_mid_value", 32'(v), 32'd5);

        // Randomised stream with upstream gaps, aborted strobes and downstream stalls
        fork
            begin : sender
                int          blk_sum;
                int          nin;
                logic [15:0] smp;
                bit          sok;
                blk_sum = 0;
                nin     = 0;
                for (int i = 0; i < 1000; i++) begin
                    repeat ($urandom_range(0, 3)) tick();
                    if ($urandom_range(0, 7) == 0 && input_z_ack == 1'b0) begin
                        input_z     = 16'($urandom);
                        input_z_stb = 1'b1;
                        tick();
                        input_z_stb = 1'b0;
                    end
                    case ($urandom_range(0, 7))
                        0:       smp = 16'h7FFF;
                        1:       smp = 16'h8000;
                        default: smp = 16'($urandom);
                    endcase
                    send(smp, sok);
                    if (!sok) chk("rand_send_timeout", 32'(sok), 32'd1);
                    blk_sum += int'($signed(smp));
                    nin++;
                    if (nin == N) begin
                        exp_q.push_back(ref_mean(blk_sum));
                        blk_sum = 0;
                        nin     = 0;
                    end
                end
                send_done = 1'b1;
            end
            begin : receiver
                bit          s;
                bit          a;
                logic [15:0] cur;
                for (int cyc = 0; cyc < 20000 && (!send_done || exp_q.size() > 0); cyc++) begin
                    output_mean_ack = ($urandom_range(0, 3) != 0);
                    s   = output_mean_stb;
                    a   = output_mean_ack;
                    cur = output_mean;
                    tick();
                    if (s && a) begin
                        if (exp_q.size() == 0) chk("rand_unexpected", 32'(cur), 32'hFFFF_FFFF);
                        else chk("rand_mean", 32'(cur), 32'(exp_q.pop_front()));
                    end
                end
                chk("rand_drained", 32'(exp_q.size()), 32'd0);
            end
        join

        output_mean_ack = 1'b1;
        outs = 0;
        for (int t = 0; t < 20; t++) begin
            if (output_mean_stb) outs++;
            tick();
        end
        chk("rand_no_extra", 32'(outs), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
